// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared defaults and response-state encoding for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_addr_w   = 7;
    localparam int c_data_w   = 32;
    localparam int c_max_wait = 4;
    localparam int c_wait_w   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2
    } resp_st_t;

    // A read response is owed to whichever port won a read this cycle.
    function automatic resp_st_t resp_next(input logic gnt0, input logic we0,
                                           input logic gnt1, input logic we1);
        resp_st_t st;
        st = IDLE;
        if (gnt0 && !we0)
            st = RD0;
        else if (gnt1 && !we1)
            st = RD1;
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_wait_ctr
// Description : Saturating starvation counter for the low-priority port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = c_max_wait
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_force
);

    localparam logic [c_wait_w-1:0] c_max = c_wait_w'(MAX_WAIT);

    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("dmem_arb_wait_ctr: MAX_WAIT out of range 1..15");
    end

    logic [c_wait_w-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wait_cnt <= '0;
        else if (!i_req || i_gnt)
            r_wait_cnt <= '0;
        else if (r_wait_cnt != c_max)
            r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    assign o_force = i_req && (r_wait_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port single-SRAM arbiter, p0 priority with p1 anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = c_addr_w,
    parameter int DATA_W   = c_data_w,
    parameter int MAX_WAIT = c_max_wait
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    logic              w_force;
    logic              w_p0_gnt;
    logic              w_p1_gnt;
    resp_st_t          r_resp_st;
    resp_st_t          w_resp_nxt;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_req   (p1_req),
        .i_gnt   (w_p1_gnt),
        .o_force (w_force)
    );

    // Grants are gated by rst so no SRAM access can start while reset is held.
    assign w_p0_gnt = p0_req && !w_force && !rst;
    assign w_p1_gnt = p1_req && !w_p0_gnt && !rst;
    assign p0_gnt   = w_p0_gnt;
    assign p1_gnt   = w_p1_gnt;
    assign mem_oen  = 1'b0;

    always_comb begin
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        mem_a   = '0;
        mem_d   = '0;
        if (w_p0_gnt) begin
            mem_cen = 1'b0;
            mem_wen = ~p0_we;
            mem_a   = p0_addr;
            mem_d   = p0_wdata;
        end else if (w_p1_gnt) begin
            mem_cen = 1'b0;
            mem_wen = ~p1_we;
            mem_a   = p1_addr;
            mem_d   = p1_wdata;
        end
    end

    always_comb begin
        w_resp_nxt = resp_next(w_p0_gnt, p0_we, w_p1_gnt, p1_we);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_resp_st <= IDLE;
        else
            r_resp_st <= w_resp_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            if (w_resp_nxt == RD0)
                r_p0_rdata <= mem_q;
            if (w_resp_nxt == RD1)
                r_p1_rdata <= mem_q;
        end
    end

    assign p0_rvalid = (r_resp_st == RD0);
    assign p1_rvalid = (r_resp_st == RD1);
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Vector-table and scoreboard bench for dmem_arbiter with SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_cen, mem_wen, mem_oen;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, mem_q;

    dmem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_oen   (mem_oen),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'(15 + a * 7);
    endfunction

    // SRAM model: unwritten words read back their init pattern (mem[0] = 15).
    logic [DW-1:0] sram [128];
    logic [127:0]  sram_wr;
    logic          sram_clear;

    assign mem_q = sram_wr[mem_a] ? sram[mem_a] : init_val(int'(mem_a));

    always @(posedge clk) begin
        if (sram_clear)
            sram_wr <= '0;
        else if (!mem_cen && !mem_wen) begin
            sram[mem_a]    <= mem_d;
            sram_wr[mem_a] <= 1'b1;
        end
    end

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          eg0, eg1;
        int            ew;
    } vec_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } resp_t;

    vec_t          vecs[$];
    resp_t         sb[$];
    logic [DW-1:0] ref_mem [128];
    logic [DW-1:0] exp_rd0, exp_rd1;
    int            checks;
    int            errors;

    function automatic vec_t mk(input logic r0, input logic w0, input int a0, input logic [DW-1:0] d0,
                                input logic r1, input logic w1, input int a1, input logic [DW-1:0] d1,
                                input logic eg0, input logic eg1, input int ew);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_resp();
        resp_t r;
        logic  ev0, ev1;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.port) begin
                ev1 = 1'b1; exp_rd1 = r.data;
            end else begin
                ev0 = 1'b1; exp_rd0 = r.data;
            end
        end
        chk("p0_rvalid", 64'(p0_rvalid), 64'(ev0));
        chk("p1_rvalid", 64'(p1_rvalid), 64'(ev1));
        chk("p0_rdata", 64'(p0_rdata), 64'(exp_rd0));
        chk("p1_rdata", 64'(p1_rdata), 64'(exp_rd1));
        chk("rvalid_excl", 64'(p0_rvalid & p1_rvalid), 64'(0));
    endtask

    task automatic step(input vec_t v);
        resp_t         r;
        logic          ecen, ewen;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(posedge clk);
        #1;
        rst = 1'b0; sram_clear = 1'b0;
        p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
        @(negedge clk);
        check_resp();
        chk("p0_gnt", 64'(p0_gnt), 64'(v.eg0));
        chk("p1_gnt", 64'(p1_gnt), 64'(v.eg1));
        chk("wait_cnt", 64'(dut.u_wait_ctr.r_wait_cnt), 64'(v.ew));
        ecen = 1'b1; ewen = 1'b1; ea = '0; ed = '0;
        if (v.eg0) begin
            ecen = 1'b0; ewen = ~v.w0; ea = v.a0; ed = v.d0;
        end else if (v.eg1) begin
            ecen = 1'b0; ewen = ~v.w1; ea = v.a1; ed = v.d1;
        end
        chk("mem_cen", 64'(mem_cen), 64'(ecen));
        chk("mem_wen", 64'(mem_wen), 64'(ewen));
        chk("mem_oen", 64'(mem_oen), 64'(0));
        chk("mem_a", 64'(mem_a), 64'(ea));
        chk("mem_d", 64'(mem_d), 64'(ed));
        if (v.eg0) begin
            if (v.w0) ref_mem[v.a0] = v.d0;
            else begin r.port = 1'b0; r.data = ref_mem[v.a0]; sb.push_back(r); end
        end else if (v.eg1) begin
            if (v.w1) ref_mem[v.a1] = v.d1;
            else begin r.port = 1'b1; r.data = ref_mem[v.a1]; sb.push_back(r); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_rd0 = '0; exp_rd1 = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

        // Table: inputs, expected grants and wait count in that cycle.
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 4, 30, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 4, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 0, 1 + i, 0,  1, 0, 5, 0,  (i % 5) != 4, (i % 5) == 4, i % 5));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 2, 0,  1, 0, 6, 0,  1, 0, 0));
        vecs.push_back(mk(1, 0, 2, 0,  1, 0, 6, 0,  1, 0, 1));
        vecs.push_back(mk(1, 0, 2, 0,  1, 0, 6, 0,  1, 0, 2));
        vecs.push_back(mk(1, 0, 2, 0,  0, 0, 6, 0,  1, 0, 3));
        vecs.push_back(mk(1, 0, 3, 0,  1, 0, 6, 0,  1, 0, 0));
        vecs.push_back(mk(1, 0, 3, 0,  1, 0, 6, 0,  1, 0, 1));
        vecs.push_back(mk(1, 0, 3, 0,  1, 0, 6, 0,  1, 0, 2));
        vecs.push_back(mk(1, 0, 3, 0,  1, 0, 6, 0,  1, 0, 3));
        vecs.push_back(mk(1, 0, 3, 0,  1, 0, 6, 0,  0, 1, 4));
        vecs.push_back(mk(1, 1, 10, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(1, 0, 10, 0, 0, 0, 0, 0,  1, 0, 0));
        vecs.push_back(mk(1, 1, 11, 32'h12345678, 1, 1, 12, 32'hA5A5A5A5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 11, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 12, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));

        // Reset held with both ports requesting: no grant, no access.
        rst = 1'b1; sram_clear = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 7'd3; p1_wdata = 32'h55;
        @(negedge clk);
        chk("rst_p0_gnt", 64'(p0_gnt), 64'(0));
        chk("rst_p1_gnt", 64'(p1_gnt), 64'(0));
        chk("rst_mem_cen", 64'(mem_cen), 64'(1));
        chk("rst_mem_wen", 64'(mem_wen), 64'(1));
        chk("rst_p0_rvalid", 64'(p0_rvalid), 64'(0));
        chk("rst_p1_rvalid", 64'(p1_rvalid), 64'(0));
        chk("rst_p0_rdata", 64'(p0_rdata), 64'(0));
        chk("rst_wait_cnt", 64'(dut.u_wait_ctr.r_wait_cnt), 64'(0));

        foreach (vecs[i]) step(vecs[i]);

        // Build up wait count, then assert reset in the middle of a granted p0 read.
        step(mk(1, 0, 1, 0,  1, 0, 5, 0,  1, 0, 0));
        step(mk(1, 0, 1, 0,  1, 0, 5, 0,  1, 0, 1));
        @(posedge clk);
        #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 7'd0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 7'd5;
        #2;
        chk("pre_rst_p0_gnt", 64'(p0_gnt), 64'(1));
        rst = 1'b1;
        #1;
        sb.delete();
        exp_rd0 = '0; exp_rd1 = '0;
        chk("mid_rst_p0_gnt", 64'(p0_gnt), 64'(0));
        chk("mid_rst_p1_gnt", 64'(p1_gnt), 64'(0));
        chk("mid_rst_mem_cen", 64'(mem_cen), 64'(1));
        chk("mid_rst_mem_wen", 64'(mem_wen), 64'(1));
        chk("mid_rst_p0_rvalid", 64'(p0_rvalid), 64'(0));
        chk("mid_rst_p0_rdata", 64'(p0_rdata), 64'(0));
        chk("mid_rst_p1_rdata", 64'(p1_rdata), 64'(0));
        chk("mid_rst_wait_cnt", 64'(dut.u_wait_ctr.r_wait_cnt), 64'(0));
        @(negedge clk);
        chk("post_edge_p0_rvalid", 64'(p0_rvalid), 64'(0));
        chk("post_edge_p0_rdata", 64'(p0_rdata), 64'(0));
        // First cycle after release must already grant.
        step(mk(1, 0, 2, 0,  0, 0, 0, 0,  1, 0, 0));
        step(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
